// File: rtl/servo_pkg.sv
// servo_pkg: shared defaults, step-table record and sequencer state type for servo_seq_pwm
package servo_pkg;
   localparam int SERVO_FRAME_TICKS   = 1000000;
   localparam int SERVO_MIN_WIDTH     = 25000;
   localparam int SERVO_MAX_WIDTH     = 125000;
   localparam int SERVO_DEFAULT_WIDTH = 75000;

   // Fields are sized for the largest supported configuration; the top slices what it needs.
   typedef struct packed {
      logic [7:0]  ch;
      logic [31:0] width;
      logic [15:0] hold;
   } servo_step_t;

   typedef enum logic [1:0] {IDLE, ARM, RUN} servo_state_e;
endpackage

// File: rtl/servo_pwm_ch.sv
// servo_pwm_ch: one servo channel with clamped target, frame-aligned active width and registered PWM compare
module servo_pwm_ch
   import servo_pkg::*;
#(
   parameter int CNT_W         = 20,
   parameter int MIN_WIDTH     = SERVO_MIN_WIDTH,
   parameter int MAX_WIDTH     = SERVO_MAX_WIDTH,
   parameter int DEFAULT_WIDTH = SERVO_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] fc_i,
   input  logic             we_i,
   input  logic [CNT_W-1:0] width_i,
   output logic             pwm_o
);
   localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_WIDTH);
   localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WIDTH);
   localparam logic [CNT_W-1:0] DEF_W = CNT_W'(DEFAULT_WIDTH);

   logic [CNT_W-1:0] target_q, target_d, active_q, active_d, clamped;

   // The active width only changes at fc == 0, so a pulse is never cut or stretched mid-frame.
   always_comb begin
      clamped  = (width_i < MIN_W) ? MIN_W : ((width_i > MAX_W) ? MAX_W : width_i);
      target_d = we_i ? clamped : target_q;
      active_d = (fc_i == '0) ? target_q : active_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_q <= DEF_W;
         active_q <= DEF_W;
         pwm_o    <= 1'b0;
      end else begin
         target_q <= target_d;
         active_q <= active_d;
         pwm_o    <= fc_i < active_d;
      end
   end
endmodule

// File: rtl/servo_seq_pwm.sv
// servo_seq_pwm: shared-frame multi-channel servo PWM with a table-driven step sequencer
module servo_seq_pwm
   import servo_pkg::*;
#(
   parameter int NUM_CH        = 2,
   parameter int NUM_STEPS     = 8,
   parameter int FRAME_TICKS   = SERVO_FRAME_TICKS,
   parameter int MIN_WIDTH     = SERVO_MIN_WIDTH,
   parameter int MAX_WIDTH     = SERVO_MAX_WIDTH,
   parameter int DEFAULT_WIDTH = SERVO_DEFAULT_WIDTH,
   parameter int HOLD_W        = 6,
   localparam int CNT_W        = $clog2(FRAME_TICKS),
   localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int STEP_W       = $clog2(NUM_STEPS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [STEP_W-1:0] cfg_addr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_width,
   input  logic [HOLD_W-1:0] cfg_hold,
   input  logic [STEP_W:0]   seq_len,
   input  logic              loop_en,
   input  logic              start,
   input  logic              abort,
   output logic [NUM_CH-1:0] servo_pwm,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] cur_step,
   output logic              frame_tick
);
   localparam logic [CNT_W-1:0]  FC_LAST  = CNT_W'(FRAME_TICKS - 1);
   localparam logic [CNT_W-1:0]  FC_ONE   = CNT_W'(1);
   localparam logic [STEP_W:0]   NS       = (STEP_W + 1)'(NUM_STEPS);
   localparam logic [STEP_W:0]   LEN_ONE  = (STEP_W + 1)'(1);
   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   logic [CNT_W-1:0]  fc_q, fc_d;
   servo_state_e      state_q, state_d;
   logic [STEP_W-1:0] cur_step_q, cur_step_d, sel;
   logic [STEP_W:0]   len_q, len_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              loop_q, loop_d, done_q, done_d, apply, tbl_we;
   servo_step_t       tbl_q [NUM_STEPS];
   servo_step_t       step;
   logic              unused_bits;

   assign frame_tick  = fc_q == FC_LAST;
   assign busy        = state_q != IDLE;
   assign done        = done_q;
   assign cur_step    = cur_step_q;
   assign tbl_we      = (state_q == IDLE) && cfg_we && ({1'b0, cfg_addr} < NS);
   assign unused_bits = ^{step.width[31:CNT_W], step.hold[15:HOLD_W]};

   always_comb begin
      fc_d       = frame_tick ? '0 : fc_q + FC_ONE;
      state_d    = state_q;
      len_d      = len_q;
      loop_d     = loop_q;
      hold_d     = hold_q;
      cur_step_d = cur_step_q;
      done_d     = 1'b0;
      apply      = 1'b0;
      sel        = cur_step_q;
      case (state_q)
         IDLE: if (start && !abort && seq_len != '0 && seq_len <= NS) begin
            state_d = ARM;
            len_d   = seq_len;
            loop_d  = loop_en;
         end
         ARM: if (abort) begin
            state_d = IDLE;
         end else if (frame_tick) begin
            state_d = RUN;
            apply   = 1'b1;
            sel     = '0;
         end
         RUN: if (abort) begin
            state_d = IDLE;
         end else if (frame_tick) begin
            if (hold_q > HOLD_ONE) begin
               hold_d = hold_q - HOLD_ONE;
            end else if ({1'b0, cur_step_q} + LEN_ONE < len_q) begin
               apply = 1'b1;
               sel   = cur_step_q + STEP_ONE;
            end else if (loop_q) begin
               apply = 1'b1;
               sel   = '0;
            end else begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      step = tbl_q[sel];
      // A zero hold still owns one full frame.
      if (apply) begin
         cur_step_d = sel;
         hold_d     = (step.hold[HOLD_W-1:0] == '0) ? HOLD_ONE : step.hold[HOLD_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fc_q       <= '0;
         state_q    <= IDLE;
         cur_step_q <= '0;
         len_q      <= '0;
         loop_q     <= 1'b0;
         hold_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         fc_q       <= fc_d;
         state_q    <= state_d;
         cur_step_q <= cur_step_d;
         len_q      <= len_d;
         loop_q     <= loop_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
      end
   end

   // The step table survives reset so a sequence can be replayed without reloading.
   always_ff @(posedge clk) begin
      if (tbl_we) tbl_q[cfg_addr] <= '{ch: 8'(cfg_ch), width: 32'(cfg_width), hold: 16'(cfg_hold)};
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      servo_pwm_ch #(
         .CNT_W        (CNT_W),
         .MIN_WIDTH    (MIN_WIDTH),
         .MAX_WIDTH    (MAX_WIDTH),
         .DEFAULT_WIDTH(DEFAULT_WIDTH)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .fc_i   (fc_q),
         .we_i   (apply && step.ch == 8'(i)),
         .width_i(step.width[CNT_W-1:0]),
         .pwm_o  (servo_pwm[i])
      );
   end
endmodule

// File: tb/tb_servo_seq_pwm.sv
// tb_servo_seq_pwm: frame-level checks of servo_seq_pwm against a step-list model of the sequencer
module tb_servo_seq_pwm;
   localparam int FR = 1000;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       cfg_we = 1'b0, loop_en = 1'b0, start = 1'b0, abort = 1'b0;
   logic [2:0] cfg_addr = '0;
   logic [0:0] cfg_ch = '0;
   logic [9:0] cfg_width = '0;
   logic [5:0] cfg_hold = '0;
   logic [3:0] seq_len = '0;
   logic [1:0] servo_pwm;
   logic       busy, done, frame_tick;
   logic [2:0] cur_step;

   servo_seq_pwm #(
      .NUM_CH(2), .NUM_STEPS(8), .FRAME_TICKS(FR), .MIN_WIDTH(50),
      .MAX_WIDTH(125), .DEFAULT_WIDTH(75), .HOLD_W(6)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_ch(cfg_ch),
      .cfg_width(cfg_width), .cfg_hold(cfg_hold), .seq_len(seq_len), .loop_en(loop_en),
      .start(start), .abort(abort), .servo_pwm(servo_pwm), .busy(busy), .done(done),
      .cur_step(cur_step), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // Frame monitor: pulse lengths per frame, step index mid-frame, event counters.
   int tb_fc = 0, frame_no = 0, cnt0 = 0, cnt1 = 0;
   int busy_cnt = 0, done_cnt = 0, done_bad = 0, ft_bad = 0;
   int meas0[256], meas1[256], mst[256];

   always @(negedge clk) begin
      if (!rst_n) begin
         tb_fc <= 0;
         cnt0  <= 0;
         cnt1  <= 0;
      end else begin
         ft_bad   <= ft_bad + int'(frame_tick != (tb_fc == FR - 1));
         done_cnt <= done_cnt + int'(done);
         done_bad <= done_bad + int'(done && tb_fc != 0);
         busy_cnt <= busy_cnt + int'(busy);
         cnt0     <= (tb_fc == FR - 1) ? 0 : cnt0 + int'(servo_pwm[0]);
         cnt1     <= (tb_fc == FR - 1) ? 0 : cnt1 + int'(servo_pwm[1]);
         if (tb_fc == 500) mst[frame_no] <= int'(cur_step);
         if (tb_fc == FR - 1) begin
            meas0[frame_no] <= cnt0 + int'(servo_pwm[0]);
            meas1[frame_no] <= cnt1 + int'(servo_pwm[1]);
            if (frame_no < 255) frame_no <= frame_no + 1;
         end
         tb_fc <= (tb_fc == FR - 1) ? 0 : tb_fc + 1;
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: the table as written, held widths, and a per-frame expectation list.
   int mt_ch[8], mt_w[8], mt_h[8];
   int mw0 = 75, mw1 = 75;
   int ew0[$], ew1[$], est[$];

   function automatic int clampw(input int w);
      return (w < 50) ? 50 : ((w > 125) ? 125 : w);
   endfunction

   task automatic build(input int len, input int reps);
      int a = mw0, b = mw1;
      ew0.delete(); ew1.delete(); est.delete();
      for (int r = 0; r < reps; r++)
         for (int k = 0; k < len; k++) begin
            if (mt_ch[k] == 0) a = clampw(mt_w[k]); else b = clampw(mt_w[k]);
            repeat ((mt_h[k] == 0) ? 1 : mt_h[k]) begin
               ew0.push_back(a); ew1.push_back(b); est.push_back(k);
            end
         end
   endtask

   task automatic wr(input int a, input int ch, input int w, input int h, input bit upd);
      cfg_addr = 3'(a); cfg_ch = 1'(ch); cfg_width = 10'(w); cfg_hold = 6'(h); cfg_we = 1'b1;
      @(posedge clk); #1 cfg_we = 1'b0;
      if (upd) begin mt_ch[a] = ch; mt_w[a] = w; mt_h[a] = h; end
   endtask

   task automatic wait_fc(input int target);
      for (int n = 0; n < 2 * FR; n++) begin
         @(posedge clk); #1;
         if (tb_fc == target) return;
      end
      chk("wait_fc_timeout", tb_fc, target);
   endtask

   task automatic wait_frames(input int target);
      int n = 0;
      while (frame_no < target && n < 20 * FR) begin @(posedge clk); n++; end
      #1;
      if (frame_no < target) chk("wait_frames_timeout", frame_no, target);
   endtask

   task automatic go(input int len, input bit lp);
      seq_len = 4'(len); loop_en = lp; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // Runs a non-looping sequence and checks every governed frame plus the held frame after it.
   task automatic run_seq(input int len, output int sf, output int c, output int bl);
      int n, b0, d0;
      build(len, 1);
      n = ew0.size();
      wait_fc(100);
      sf = frame_no; c = tb_fc; b0 = busy_cnt; d0 = done_cnt;
      go(len, 1'b0);
      wait_frames(sf + n + 2);
      for (int k = 0; k < n; k++) begin
         chk("run_w0", meas0[sf + 1 + k], ew0[k]);
         chk("run_w1", meas1[sf + 1 + k], ew1[k]);
         chk("run_step", mst[sf + 1 + k], est[k]);
      end
      chk("held_w0", meas0[sf + n + 1], ew0[n - 1]);
      chk("held_w1", meas1[sf + n + 1], ew1[n - 1]);
      bl = busy_cnt - b0;
      chk("busy_len", bl, (FR - 1 - c) + n * FR);
      chk("done_pulses", done_cnt - d0, 1);
      chk("busy_after", int'(busy), 0);
      mw0 = ew0[n - 1]; mw1 = ew1[n - 1];
   endtask

   typedef struct {int w; int h; int exp_w; int exp_fr;} vec_t;
   vec_t vt[4];

   initial begin
      int sf, c, bl, d0, e;
      vt[0] = '{200, 1, 125, 1};
      vt[1] = '{30, 0, 50, 1};
      vt[2] = '{100, 2, 100, 2};
      vt[3] = '{51, 0, 51, 1};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_pwm", int'(servo_pwm), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_step", int'(cur_step), 0);
      chk("rst_ftick", int'(frame_tick), 0);
      rst_n = 1'b1;
      wait_frames(3);
      for (int k = 0; k < 2; k++) begin
         chk("idle_w0", meas0[k], 75);
         chk("idle_w1", meas1[k], 75);
      end
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", done_cnt, 0);

      // Rejected starts.
      seq_len = 4'd0; start = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("rej_len0", int'(busy), 0);
      seq_len = 4'd9;
      repeat (2) @(posedge clk);
      #1 chk("rej_len9", int'(busy), 0);
      seq_len = 4'd3; abort = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("rej_abort", int'(busy), 0);
      start = 1'b0; abort = 1'b0;

      // Arm-and-gripper style sequence.
      wr(0, 1, 118, 2, 1);
      wr(1, 0, 115, 1, 1);
      wr(2, 0, 15, 3, 1);
      run_seq(3, sf, c, bl);
      chk("seq_clamped_last", meas0[sf + 6], 50);

      // Looping, latched length/loop, dropped busy write, abort mid-step.
      build(3, 2);
      wait_fc(100);
      sf = frame_no; d0 = done_cnt;
      go(3, 1'b1);
      wr(0, 0, 60, 1, 0);
      seq_len = 4'd1; loop_en = 1'b0;
      wait_frames(sf + 9);
      wait_fc(500);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_step", int'(cur_step), est[8]);
      wait_frames(sf + 11);
      for (int k = 0; k < 8; k++) begin
         chk("loop_w0", meas0[sf + 1 + k], ew0[k]);
         chk("loop_w1", meas1[sf + 1 + k], ew1[k]);
         chk("loop_step", mst[sf + 1 + k], est[k]);
      end
      chk("abort_held0", meas0[sf + 10], ew0[8]);
      chk("abort_held1", meas1[sf + 10], ew1[8]);
      chk("loop_no_done", done_cnt - d0, 0);
      chk("abort_step_hold", int'(cur_step), est[8]);
      mw0 = ew0[8]; mw1 = ew1[8];

      // Asynchronous reset in the middle of step 1.
      build(3, 1);
      wait_fc(100);
      sf = frame_no;
      go(3, 1'b0);
      wait_frames(sf + 3);
      wait_fc(60);
      e = ((59 < ew1[2]) ? 2 : 0) + ((59 < ew0[2]) ? 1 : 0);
      chk("pre_rst_pwm", int'(servo_pwm), e);
      chk("pre_rst_step", int'(cur_step), est[2]);
      rst_n = 1'b0;
      #1;
      chk("arst_pwm", int'(servo_pwm), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_step", int'(cur_step), 0);
      chk("arst_done", int'(done), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      mw0 = 75; mw1 = 75;
      run_seq(3, sf, c, bl);

      // Clamp and hold=0 vectors, single step on channel 0.
      for (int i = 0; i < 4; i++) begin
         wr(0, 0, vt[i].w, vt[i].h, 1);
         run_seq(1, sf, c, bl);
         chk("vec_width", meas0[sf + 1], vt[i].exp_w);
         chk("vec_last", meas0[sf + vt[i].exp_fr], vt[i].exp_w);
         chk("vec_busy", bl, (FR - 1 - c) + vt[i].exp_fr * FR);
      end

      // Randomized tables.
      for (int it = 0; it < 2; it++) begin
         for (int k = 0; k < 3; k++)
            wr(k, int'($urandom_range(0, 1)), int'($urandom_range(0, 250)), int'($urandom_range(0, 2)), 1);
         run_seq(int'($urandom_range(1, 3)), sf, c, bl);
      end

      chk("frame_tick_align", ft_bad, 0);
      chk("done_at_fc0", done_bad, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
